fpga_ddr3_dmaster_b2p: RTL and testbench
========================================

# fpga_ddr3_dmaster_b2p

Byte-stream-to-packet decoder for the DDR3 debug master path. Consumes the raw 8-bit Avalon-ST byte stream from the JTAG/byte transport. Strips the in-band framing codes (SOP 0x7A, EOP 0x7B, channel 0x7C, escape 0x7D). Emits an Avalon-ST packet stream with data, channel, startofpacket and endofpacket to the downstream channel adapter.

## Interface
Parameters:
- CHANNEL_WIDTH, 8: width of out_channel; the channel byte is truncated to its low CHANNEL_WIDTH bits.

Ports:
- clk  input  1  single clock for all logic
- reset  input  1  asynchronous, active-high reset
- in_ready  output  1  byte sink ready
- in_valid  input  1  byte valid
- in_data  input  8  encoded byte
- out_ready  input  1  downstream ready
- out_valid  output  1  decoded data byte valid
- out_data  output  8  decoded data byte
- out_channel  output  CHANNEL_WIDTH  channel of current byte
- out_startofpacket  output  1  first byte of packet
- out_endofpacket  output  1  last byte of packet

Reset/clocking (decided): one clock `clk`; `reset` is asynchronous and active-high.

## Operation
- Input accept: `in_valid && in_ready`.
- `in_ready = out_ready || !out_valid`, combinational. A one-entry output register may drain and reload in the same cycle.
- Decoder state machine:
  - DATA: initial state.
  - ESC: the next byte is escaped data.
  - CHAN: the next byte is a channel number.
  - CHAN_ESC: the next byte is an escaped channel number.
- DATA state:
  - 0x7A: set sop_pending; stay in DATA.
  - 0x7B: set eop_pending; stay in DATA.
  - 0x7C: go to CHAN.
  - 0x7D: go to ESC.
  - Any other byte: emit a data byte.
- ESC state: emit a data byte with value `in_data ^ 0x20`; return to DATA.
- CHAN state:
  - 0x7A: set sop_pending; stay in CHAN.
  - 0x7B: set eop_pending; stay in CHAN.
  - 0x7C: stay in CHAN.
  - 0x7D: go to CHAN_ESC.
  - Any other byte: load channel_reg with that byte; go to DATA.
- CHAN_ESC state: load channel_reg with `in_data ^ 0x20`; go to DATA.
- Emitting a data byte:
  - Load out_data and out_channel. out_channel takes the current channel_reg.
  - Set out_startofpacket = sop_pending and out_endofpacket = eop_pending.
  - Set out_valid = 1.
  - Clear both pending flags in the same cycle.
- Marker and channel bytes produce no output beat.
- channel_reg persists across packets until it is rewritten.
- If SOP and EOP are both pending, the next data byte carries both flags (single-byte packet).
- A repeated marker of the same kind before any data byte is idempotent.
- The decoder does no packet-structure checking: EOP without a prior SOP, or a missing EOP, passes through as flagged.

## Timing
- Reset values: out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0. Internally: state=DATA, sop_pending=0, eop_pending=0, channel_reg=0.
- Reset is asynchronous. Asserting it mid-packet or mid-escape discards any held output beat and all pending state immediately.
- Latency: a data byte accepted in cycle N appears on the outputs in cycle N+1.
- Throughput: one byte per cycle when out_ready stays high.
- Backpressure: while `out_valid && !out_ready`, all outputs hold stable and in_ready=0. The decoder state does not advance.
- out_valid falls the cycle after the beat is taken, unless a new data byte is accepted in that same cycle.
- A channel update accepted in cycle N applies to data bytes accepted in cycle N+1 and later. It never affects a beat already held in the output register.

## Test plan
- Framing:
  - Stimulus: 7A 7C 05 11 22 7B 33 with out_ready=1.
  - Required: three beats.
    - 0x11, channel 5, SOP=1, EOP=0
    - 0x22, channel 5, SOP=0, EOP=0
    - 0x33, channel 5, SOP=0, EOP=1
  - Each beat appears one cycle after its input byte.
- Escapes:
  - Stimulus: 7A 7D 5A 7D 5D 7B 7D 5B.
  - Required: beats 0x7A (SOP), 0x7D, 0x7B (EOP), all on channel 0.
- Escaped channel and single-byte packet:
  - Stimulus: 7C 7D 5C 7A 7B 44.
  - Required: one beat, 0x44, channel 0x7C, SOP=1, EOP=1.
- Backpressure:
  - Stimulus: stream 7A 01 02 7B 03 while toggling out_ready 1,0,0,1,0,1.
  - Required: output beats 01, 02, 03 each delivered exactly once with their flags.
  - While stalled, outputs are stable and in_ready=0.
  - No byte is lost or duplicated.
- Reset mid-operation:
  - Stimulus: send 7C 09 7A 7D, then pulse reset asynchronously, then send 55.
  - Required: all outputs go to 0 during reset.
  - After reset, 0x55 emits on channel 0 with SOP=0, EOP=0, and is not XORed.

Source files
------------

// File: rtl/fpga_ddr3_dmaster_b2p.sv
// ---------------------------------------------------------------------------
// fpga_ddr3_dmaster_b2p
//
// Byte-stream to Avalon-ST packet decoder for the DDR3 debug master path.
// Removes the in-band framing codes (0x7A SOP, 0x7B EOP, 0x7C channel,
// 0x7D escape) from the raw transport byte stream. Each remaining data byte
// becomes one beat carrying the current channel and any pending SOP/EOP.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   in_ready/valid/data encoded byte sink
//   out_ready/valid     decoded beat handshake (one-entry output register)
//   out_data            decoded data byte
//   out_channel         channel of the beat (low CHANNEL_WIDTH bits)
//   out_startofpacket   first byte of packet
//   out_endofpacket     last byte of packet
// ---------------------------------------------------------------------------
module fpga_ddr3_dmaster_b2p #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket
);

    localparam logic [7:0] SOP_CODE  = 8'h7A;
    localparam logic [7:0] EOP_CODE  = 8'h7B;
    localparam logic [7:0] CHAN_CODE = 8'h7C;
    localparam logic [7:0] ESC_CODE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [1:0] {
        ST_DATA,
        ST_ESC,
        ST_CHAN,
        ST_CHAN_ESC
    } state_t;

    state_t                   state, next_state;
    logic                     sop_pending, sop_next;
    logic                     eop_pending, eop_next;
    logic [CHANNEL_WIDTH-1:0] channel_reg, channel_next;
    logic                     accept;
    logic                     emit;
    logic [7:0]               emit_byte;
    logic [7:0]               chan_byte;

    // The output register may drain and reload in the same cycle.
    assign in_ready = out_ready || !out_valid;
    assign accept   = in_valid && in_ready;

    // Escaped channel bytes are unescaped before truncation to the port width.
    assign chan_byte = (state == ST_CHAN_ESC) ? (in_data ^ ESC_XOR) : in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_DATA;
            sop_pending <= 1'b0;
            eop_pending <= 1'b0;
            channel_reg <= '0;
        end else begin
            state       <= next_state;
            sop_pending <= sop_next;
            eop_pending <= eop_next;
            channel_reg <= channel_next;
        end
    end

    always_comb begin
        next_state   = state;
        sop_next     = sop_pending;
        eop_next     = eop_pending;
        channel_next = channel_reg;
        emit         = 1'b0;
        emit_byte    = in_data;
        if (accept) begin
            unique case (state)
                ST_DATA: begin
                    if (in_data == SOP_CODE)       sop_next   = 1'b1;
                    else if (in_data == EOP_CODE)  eop_next   = 1'b1;
                    else if (in_data == CHAN_CODE) next_state = ST_CHAN;
                    else if (in_data == ESC_CODE)  next_state = ST_ESC;
                    else                           emit       = 1'b1;
                end
                ST_ESC: begin
                    emit       = 1'b1;
                    emit_byte  = in_data ^ ESC_XOR;
                    next_state = ST_DATA;
                end
                ST_CHAN: begin
                    // Markers may interleave with the channel prefix.
                    if (in_data == SOP_CODE)       sop_next   = 1'b1;
                    else if (in_data == EOP_CODE)  eop_next   = 1'b1;
                    else if (in_data == CHAN_CODE) next_state = ST_CHAN;
                    else if (in_data == ESC_CODE)  next_state = ST_CHAN_ESC;
                    else begin
                        channel_next = CHANNEL_WIDTH'(chan_byte);
                        next_state   = ST_DATA;
                    end
                end
                ST_CHAN_ESC: begin
                    channel_next = CHANNEL_WIDTH'(chan_byte);
                    next_state   = ST_DATA;
                end
                default: next_state = ST_DATA;
            endcase
            // The beat consumes whatever markers were pending.
            if (emit) begin
                sop_next = 1'b0;
                eop_next = 1'b0;
            end
        end
    end

    // One-entry output register. Data fields only change on a new beat,
    // so they hold stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_channel       <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end else if (emit) begin
            out_valid         <= 1'b1;
            out_data          <= emit_byte;
            out_channel       <= channel_reg;
            out_startofpacket <= sop_pending;
            out_endofpacket   <= eop_pending;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpga_ddr3_dmaster_b2p.sv
module tb_fpga_ddr3_dmaster_b2p;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] out_channel;
    logic       out_startofpacket;
    logic       out_endofpacket;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpga_ddr3_dmaster_b2p #(.CHANNEL_WIDTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_channel      (out_channel),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket)
    );

    // One vector = one clock cycle. Expected outputs are those visible
    // during that cycle (i.e. the result of earlier cycles), plus the
    // combinational in_ready for the out_ready driven in that cycle.
    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_d;
        logic [7:0] e_ch;
        logic       e_s;
        logic       e_e;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic iv, input logic [7:0] d,
                       input logic ordy, input logic e_ir, input logic e_ov,
                       input logic [7:0] e_d, input logic [7:0] e_ch,
                       input logic e_s, input logic e_e, input string tag);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.ordy = ordy; v.e_ir = e_ir;
        v.e_ov = e_ov; v.e_d = e_d; v.e_ch = e_ch; v.e_s = e_s; v.e_e = e_e;
        v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic e_ov, input logic [7:0] e_d,
                                 input logic [7:0] e_ch, input logic e_s, input logic e_e);
        chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
        if (e_ov) begin
            chk({tag, " out_data"}, {24'd0, out_data}, {24'd0, e_d});
            chk({tag, " out_channel"}, {24'd0, out_channel}, {24'd0, e_ch});
            chk({tag, " sop"}, {31'd0, out_startofpacket}, {31'd0, e_s});
            chk({tag, " eop"}, {31'd0, out_endofpacket}, {31'd0, e_e});
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_data", {24'd0, out_data}, 32'd0);
        chk("reset out_channel", {24'd0, out_channel}, 32'd0);
        chk("reset sop", {31'd0, out_startofpacket}, 32'd0);
        chk("reset eop", {31'd0, out_endofpacket}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- framing: 7A 7C 05 11 22 7B 33 ----------------
        add(0,1,8'h7A,1, 1,0,8'h00,8'h00,0,0, "frm0");
        add(0,1,8'h7C,1, 1,0,8'h00,8'h00,0,0, "frm1");
        add(0,1,8'h05,1, 1,0,8'h00,8'h00,0,0, "frm2");
        add(0,1,8'h11,1, 1,0,8'h00,8'h00,0,0, "frm3");
        add(0,1,8'h22,1, 1,1,8'h11,8'h05,1,0, "frm4");
        add(0,1,8'h7B,1, 1,1,8'h22,8'h05,0,0, "frm5");
        add(0,1,8'h33,1, 1,0,8'h00,8'h00,0,0, "frm6");
        add(0,0,8'h00,1, 1,1,8'h33,8'h05,0,1, "frm7");
        add(0,0,8'h00,1, 1,0,8'h00,8'h00,0,0, "frm8");

        // ---------------- escapes: 7A 7D 5A 7D 5D 7B 7D 5B ----------------
        add(1,1,8'h7A,1, 1,0,8'h00,8'h00,0,0, "esc0");
        add(0,1,8'h7D,1, 1,0,8'h00,8'h00,0,0, "esc1");
        add(0,1,8'h5A,1, 1,0,8'h00,8'h00,0,0, "esc2");
        add(0,1,8'h7D,1, 1,1,8'h7A,8'h00,1,0, "esc3");
        add(0,1,8'h5D,1, 1,0,8'h00,8'h00,0,0, "esc4");
        add(0,1,8'h7B,1, 1,1,8'h7D,8'h00,0,0, "esc5");
        add(0,1,8'h7D,1, 1,0,8'h00,8'h00,0,0, "esc6");
        add(0,1,8'h5B,1, 1,0,8'h00,8'h00,0,0, "esc7");
        add(0,0,8'h00,1, 1,1,8'h7B,8'h00,0,1, "esc8");
        add(0,0,8'h00,1, 1,0,8'h00,8'h00,0,0, "esc9");

        // ---------------- escaped channel + single-byte packet ----------------
        add(1,1,8'h7C,1, 1,0,8'h00,8'h00,0,0, "ech0");
        add(0,1,8'h7D,1, 1,0,8'h00,8'h00,0,0, "ech1");
        add(0,1,8'h5C,1, 1,0,8'h00,8'h00,0,0, "ech2");
        add(0,1,8'h7A,1, 1,0,8'h00,8'h00,0,0, "ech3");
        add(0,1,8'h7B,1, 1,0,8'h00,8'h00,0,0, "ech4");
        add(0,1,8'h44,1, 1,0,8'h00,8'h00,0,0, "ech5");
        add(0,0,8'h00,1, 1,1,8'h44,8'h7C,1,1, "ech6");
        add(0,0,8'h00,1, 1,0,8'h00,8'h00,0,0, "ech7");

        // ---------------- backpressure: 7A 01 02 7B 03, ready 1,0,0,1,0,1 ----------------
        // A byte refused while in_ready=0 is re-driven on the next vector.
        add(1,1,8'h7A,1, 1,0,8'h00,8'h00,0,0, "bp0");
        add(0,1,8'h01,0, 1,0,8'h00,8'h00,0,0, "bp1");
        add(0,1,8'h02,0, 0,1,8'h01,8'h00,1,0, "bp2");
        add(0,1,8'h02,1, 1,1,8'h01,8'h00,1,0, "bp3");
        add(0,1,8'h7B,0, 0,1,8'h02,8'h00,0,0, "bp4");
        add(0,1,8'h7B,1, 1,1,8'h02,8'h00,0,0, "bp5");
        add(0,1,8'h03,1, 1,0,8'h00,8'h00,0,0, "bp6");
        add(0,0,8'h00,1, 1,1,8'h03,8'h00,0,1, "bp7");
        add(0,0,8'h00,1, 1,0,8'h00,8'h00,0,0, "bp8");

        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            #1;
            chk({vecs[i].tag, " in_ready"}, {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
            check_outputs(vecs[i].tag, vecs[i].e_ov, vecs[i].e_d, vecs[i].e_ch,
                          vecs[i].e_s, vecs[i].e_e);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // ---------------- stall stability over several cycles ----------------
        pulse_reset();
        out_ready = 1'b0;
        send(8'h7C); send(8'h03); send(8'h7A); send(8'h7B); send(8'h66);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall in_ready", {31'd0, in_ready}, 32'd0);
            check_outputs("stall", 1'b1, 8'h66, 8'h03, 1'b1, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_outputs("stall release", 1'b1, 8'h77, 8'h03, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_outputs("stall drain", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        // ---------------- async reset mid-escape ----------------
        send(8'h7C); send(8'h09); send(8'h7A); send(8'h7D);
        #1;
        reset = 1'b1;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst out_data", {24'd0, out_data}, 32'd0);
        chk("async rst out_channel", {24'd0, out_channel}, 32'd0);
        chk("async rst sop", {31'd0, out_startofpacket}, 32'd0);
        chk("async rst eop", {31'd0, out_endofpacket}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h55);
        #1;
        check_outputs("post rst", 1'b1, 8'h55, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
